// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: ALUOp codes, FSM states, default width.
package alu_arbiter_pkg;

  localparam int DATA_W_DEFAULT = 32;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SRL = 3'b100;
  localparam logic [2:0] OP_SRA = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU shared by the arbiter; undefined encodings produce zero and flag err.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] c,
  output logic              err
);

  logic                     shift_sat;
  logic signed [DATA_W-1:0] sra_res;

  // The whole of b is the shift amount, so anything at or past the width saturates.
  assign shift_sat = (b >= DATA_W'(DATA_W));
  assign sra_res   = $signed(a) >>> b;

  always_comb begin
    c   = '0;
    err = 1'b0;
    case (op)
      OP_ADD:  c = a + b;
      OP_SUB:  c = a - b;
      OP_AND:  c = a & b;
      OP_OR:   c = a | b;
      OP_SRL:  c = shift_sat ? '0 : (a >> b);
      OP_SRA:  c = shift_sat ? {DATA_W{a[DATA_W-1]}} : sra_res;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_arbiter_pick.sv
// Grant selection between two requesters: a lone valid always wins, a tie goes to the
// requester named by the priority pointer.
module alu_arbiter_pick (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester ALU front end: IDLE grants and captures, EXEC computes, RESP holds the result.
// Define ALU_ARBITER_RR_EN for round-robin contention; otherwise requester 0 has fixed priority.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [2:0]        req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [2:0]        req1_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_c,
  output logic              rsp_id,
  output logic              rsp_err
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]        op_q, op_d;
  logic              id_q, id_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_c_q, rsp_c_d;
  logic              rsp_id_q, rsp_id_d;
  logic              rsp_err_q, rsp_err_d;

  logic [1:0]        grant;
  logic              in_idle;
  logic              ptr;
  logic [DATA_W-1:0] alu_c;
  logic              alu_err;

`ifdef ALU_ARBITER_RR_EN
  logic ptr_q, ptr_d;
  assign ptr = ptr_q;
`else
  assign ptr = 1'b0;
`endif

  alu_arbiter_pick u_pick (
    .valid (({req1_valid, req0_valid})),
    .ptr   (ptr),
    .grant (grant)
  );

  alu_arbiter_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a   (a_q),
    .b   (b_q),
    .op  (op_q),
    .c   (alu_c),
    .err (alu_err)
  );

  assign in_idle    = (state_q == ST_IDLE) && !reset;
  assign req0_ready = in_idle && grant[0];
  assign req1_ready = in_idle && grant[1];

  assign rsp_valid  = rsp_valid_q;
  assign rsp_c      = rsp_c_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_err    = rsp_err_q;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_c_d     = rsp_c_q;
    rsp_id_d    = rsp_id_q;
    rsp_err_d   = rsp_err_q;
`ifdef ALU_ARBITER_RR_EN
    ptr_d       = ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (grant != 2'b00) begin
          a_d     = grant[1] ? req1_a  : req0_a;
          b_d     = grant[1] ? req1_b  : req0_b;
          op_d    = grant[1] ? req1_op : req0_op;
          id_d    = grant[1];
          state_d = ST_EXEC;
`ifdef ALU_ARBITER_RR_EN
          // The requester that just lost priority gets it back for the next tie.
          ptr_d   = ~grant[1];
`endif
        end
      end
      ST_EXEC: begin
        rsp_c_d     = alu_c;
        rsp_err_d   = alu_err;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_c_q     <= '0;
      rsp_id_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
`ifdef ALU_ARBITER_RR_EN
      ptr_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_c_q     <= rsp_c_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
`ifdef ALU_ARBITER_RR_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: DATA_W, default 32, operand/result width in bits.
REQ-002 Port: clk  input  1  rising-edge clock; the block has one clock.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: req0_valid  input  1  requester 0 has an operation pending.
REQ-005 Port: req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 Port: req0_a / req0_b  input  DATA_W each  requester 0 operands A, B.
REQ-007 Port: req0_op  input  3  requester 0 ALUOp.
REQ-008 Port: req1_valid, req1_ready, req1_a, req1_b, req1_op  same directions/widths/meaning for requester 1.
REQ-009 Port: rsp_valid  output  1  result held on rsp_c.
REQ-010 Port: rsp_ready  input  1  consumer takes result this cycle.
REQ-011 Port: rsp_c  output  DATA_W  result.
REQ-012 Port: rsp_id  output  1  requester that issued the result.
REQ-013 Port: rsp_err  output  1  issued op was an undefined encoding.

Function
REQ-014 ALUOp encoding: 000 A+B; 001 A-B; 010 A&B; 011 A|B; 100 A>>B logical; 101 A>>>B arithmetic; 110/111 undefined, result 0.
REQ-015 Arithmetic: add/sub modulo 2^DATA_W, carry/borrow dropped; shift amount is the full B value, B>=DATA_W gives 0 (logical) or all sign bits (arithmetic).
REQ-016 FSM states: IDLE, EXEC, RESP; one-hot or binary encoding is free.
REQ-017 IDLE: if any req*_valid, assert req*_ready combinationally for exactly one granted requester; on handshake, register A, B, op, id; go to EXEC.
REQ-018 Only in IDLE is any req*_ready high; both readies are never high in the same cycle.
REQ-019 EXEC: drive the registered operands through the ALU; register result into rsp_c, set rsp_err for op 110/111, assert rsp_valid; go to RESP.
REQ-020 RESP: hold rsp_valid, rsp_c, rsp_id, rsp_err stable until rsp_valid&&rsp_ready; then deassert rsp_valid and go to IDLE next cycle.
REQ-021 Latency: accept in cycle N gives rsp_valid in cycle N+2; peak throughput is one op per 3 cycles.
REQ-022 Requester operands and valid may change after the handshake without affecting the in-flight op.
REQ-023 Grant with only one valid: that requester, regardless of priority state.
REQ-024 Grant with both valid: see Configuration; the priority pointer updates only on an accepting handshake.

Reset
REQ-025 On reset high at a clock edge: state=IDLE, rsp_valid=0, rsp_c=0, rsp_id=0, rsp_err=0, priority pointer=requester 0.
REQ-026 Reset during EXEC or RESP discards the in-flight op; no rsp_valid is produced for it.
REQ-027 While reset is high, req0_ready and req1_ready are 0.

Configuration
REQ-028 Macro ALU_ARBITER_RR_EN defined: round-robin; after a grant to requester k, requester 1-k wins the next contention.
REQ-029 Macro ALU_ARBITER_RR_EN undefined: fixed priority, requester 0 always wins contention; the priority pointer is absent.

Structure
REQ-030 Shared package holds the ALUOp localparams (OP_ADD..OP_SRA), the FSM state typedef and the DATA_W default.
REQ-031 The grant logic is one sub-module, alu_arbiter_pick (valids and pointer in, one-hot grant out); the datapath is the team's existing combinational ALU instantiated once.

Verification
REQ-032 Single op: req0 valid, a=5, b=3, op=001, rsp_ready=1 -> rsp_valid 2 cycles after handshake, rsp_c=2, rsp_id=0, rsp_err=0.
REQ-033 Contention, RR_EN: both valid continuously, op=000, req0 a=1 b=1, req1 a=2 b=2 -> results alternate 2(id0), 4(id1), 2(id0)...; without the macro -> all id0.
REQ-034 Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_c stable, both req*_ready stay 0, release -> IDLE next cycle.
REQ-035 Shifts/undefined: a=32'h8000_0000, b=4, op=101 -> 32'hF800_0000; op=100 with b=40 -> 0; op=111 -> rsp_c=0, rsp_err=1.
REQ-036 Reset mid-op: assert reset in EXEC cycle -> no rsp_valid appears, all outputs 0, next request accepted normally.
